// File: rtl/mc14500_pkg.sv
// Shared types for the MC14500 instruction fetch path.
package mc14500_pkg;

  localparam int unsigned OPCODE_WIDTH = 4;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    NOPO = 4'h0,
    LD   = 4'h1,
    LDC  = 4'h2,
    AND  = 4'h3,
    ANDC = 4'h4,
    OR   = 4'h5,
    ORC  = 4'h6,
    XNOR = 4'h7,
    STO  = 4'h8,
    STOC = 4'h9,
    IEN  = 4'hA,
    OEN  = 4'hB,
    JMP  = 4'hC,
    RTN  = 4'hD,
    SKZ  = 4'hE,
    NOPF = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    WAIT_LOW = 3'd0,
    IDLE     = 3'd1,
    FETCH    = 3'd2,
    ISSUE    = 3'd3,
    RELEASE  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/handshake_sync.sv
// Multi-flop synchronizer for an asynchronous handshake line.
module handshake_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_ff;

  // Shift the async level through the chain; reset to idle-low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_ff <= '0;
    else        sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
  end

  assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/fetch_responder.sv
// Fetch responder: services PC address requests, reads ROM, issues the instruction to the ALU stage.
module fetch_responder
  import mc14500_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned OPERAND_WIDTH = 4,
  parameter int unsigned ROM_LATENCY   = 1,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req_in,
  input  logic [ADDR_WIDTH-1:0]               address_in,
  output logic                                ack_out,
  output logic                                rom_rd,
  output logic [ADDR_WIDTH-1:0]               rom_addr,
  input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] rom_data,
  output logic [OPCODE_WIDTH-1:0]             opcode,
  output logic [OPERAND_WIDTH-1:0]            operand,
  output logic                                req_out,
  input  logic                                ack_in,
  output logic                                pc_write,
  output logic [ADDR_WIDTH-1:0]               pc_address,
  output logic                                flag_o,
  output logic                                flag_f
);

  // The counter times both the ROM latency and the synchronizer fill after reset.
  localparam int unsigned CNT_MAX = (ROM_LATENCY > SYNC_STAGES) ? ROM_LATENCY : SYNC_STAGES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  fetch_state_e state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic req_s, ack_s;

  logic                     rom_rd_d, req_out_d, ack_out_d, pc_write_d, flag_o_d, flag_f_d;
  logic [ADDR_WIDTH-1:0]    rom_addr_d, pc_address_d;
  logic [OPCODE_WIDTH-1:0]  opcode_d;
  logic [OPERAND_WIDTH-1:0] operand_d;

  opcode_e                  rom_op;
  logic [OPERAND_WIDTH-1:0] rom_opnd;

  assign rom_op   = opcode_e'(rom_data[OPERAND_WIDTH +: OPCODE_WIDTH]);
  assign rom_opnd = rom_data[OPERAND_WIDTH-1:0];

  handshake_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk(clk), .rst_n(rst_n), .d(req_in), .q(req_s)
  );

  handshake_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk(clk), .rst_n(rst_n), .d(ack_in), .q(ack_s)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_LOW;
      cnt        <= '0;
      rom_rd     <= 1'b0;
      rom_addr   <= '0;
      opcode     <= '0;
      operand    <= '0;
      pc_write   <= 1'b0;
      pc_address <= '0;
      flag_o     <= 1'b0;
      flag_f     <= 1'b0;
      req_out    <= 1'b0;
      ack_out    <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      rom_rd     <= rom_rd_d;
      rom_addr   <= rom_addr_d;
      opcode     <= opcode_d;
      operand    <= operand_d;
      pc_write   <= pc_write_d;
      pc_address <= pc_address_d;
      flag_o     <= flag_o_d;
      flag_f     <= flag_f_d;
      req_out    <= req_out_d;
      ack_out    <= ack_out_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    rom_rd_d     = 1'b0;
    rom_addr_d   = rom_addr;
    opcode_d     = opcode;
    operand_d    = operand;
    pc_write_d   = pc_write;
    pc_address_d = pc_address;
    flag_o_d     = 1'b0;
    flag_f_d     = 1'b0;
    req_out_d    = req_out;
    ack_out_d    = ack_out;

    unique case (state)
      // Let the synchronizer fill first so a req_in held through reset is seen and skipped.
      WAIT_LOW: begin
        if (cnt < CNT_W'(SYNC_STAGES)) cnt_d = cnt + CNT_W'(1);
        else if (!req_s)               state_d = IDLE;
      end
      IDLE: begin
        if (req_s) begin
          rom_addr_d = address_in;
          rom_rd_d   = 1'b1;
          cnt_d      = '0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (cnt == CNT_W'(ROM_LATENCY)) begin
          opcode_d   = rom_op;
          operand_d  = rom_opnd;
          pc_write_d = (rom_op == JMP);
          if (rom_op == JMP) pc_address_d = ADDR_WIDTH'(rom_opnd);
          flag_o_d   = (rom_op == NOPO);
          flag_f_d   = (rom_op == NOPF);
          state_d    = ISSUE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      // First ISSUE cycle lets the data settle ahead of req_out.
      ISSUE: begin
        if (!req_out) begin
          req_out_d = 1'b1;
        end else if (ack_s) begin
          req_out_d = 1'b0;
          ack_out_d = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_s && !req_s) begin
          ack_out_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

endmodule

// File: tb/tb_fetch_responder.sv
// Self-checking bench for fetch_responder: table vectors, random fetches, reset corner cases.
module tb_fetch_responder;

  localparam int unsigned AW  = 8;
  localparam int unsigned OW  = 4;
  localparam int unsigned LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_in;
  logic [AW-1:0] address_in;
  logic          ack_out;
  logic          rom_rd;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [3:0]    opcode;
  logic [OW-1:0] operand;
  logic          req_out;
  logic          ack_in;
  logic          pc_write;
  logic [AW-1:0] pc_address;
  logic          flag_o;
  logic          flag_f;

  logic [7:0] rom [256];

  int checks = 0;
  int errors = 0;
  int mdl_pc = 0;

  fetch_responder #(.ADDR_WIDTH(AW), .OPERAND_WIDTH(OW), .ROM_LATENCY(LAT), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .address_in(address_in), .ack_out(ack_out),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data), .opcode(opcode), .operand(operand),
    .req_out(req_out), .ack_in(ack_in), .pc_write(pc_write), .pc_address(pc_address),
    .flag_o(flag_o), .flag_f(flag_f)
  );

  always #5 clk = ~clk;

  // Program ROM with one cycle of read latency.
  always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] word;
    int         mode;
    int         exp_op;
    int         exp_opnd;
    int         exp_pcw;
    int         exp_pca;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full fetch; mode 0: req_in/ack_in drop together, 1: req_in first, 2: ack_in first.
  task automatic do_fetch(input vec_t v);
    int k, krd, kreq, nrd, nfo, nff, bad;
    logic [7:0] rd_addr;
    k = 0; krd = -1; kreq = -1; nrd = 0; nfo = 0; nff = 0; bad = 0; rd_addr = '0;
    rom[v.addr] = v.word;
    @(negedge clk);
    address_in = v.addr;
    req_in     = 1'b1;
    while (kreq < 0 && k < 40) begin
      cyc(); k++;
      if (rom_rd) begin nrd++; if (krd < 0) begin krd = k; rd_addr = rom_addr; end end
      nfo += int'(flag_o); nff += int'(flag_f);
      if (req_out) kreq = k;
    end
    chk("req_out_rise", int'(kreq >= 0), 1);
    chk("rom_addr", int'(rd_addr), int'(v.addr));
    chk("issue_latency", kreq - krd, int'(LAT) + 2);
    chk("opcode", int'(opcode), v.exp_op);
    chk("operand", int'(operand), v.exp_opnd);
    chk("pc_write", int'(pc_write), v.exp_pcw);
    chk("pc_address", int'(pc_address), v.exp_pca);
    ack_in = 1'b1;
    k = 0;
    while (!ack_out && k < 20) begin
      cyc(); k++;
      if (rom_rd) nrd++;
      nfo += int'(flag_o); nff += int'(flag_f);
    end
    chk("ack_out_rise", int'(ack_out), 1);
    chk("req_out_drop", int'(req_out), 0);
    if (v.mode == 1) begin
      req_in = 1'b0;
      repeat (10) begin cyc(); if (!ack_out) bad++; end
    end else if (v.mode == 2) begin
      ack_in = 1'b0;
      repeat (10) begin cyc(); if (!ack_out) bad++; end
    end
    if (v.mode != 0) chk("ack_out_hold", bad, 0);
    req_in = 1'b0;
    ack_in = 1'b0;
    k = 0;
    while (ack_out && k < 20) begin
      cyc(); k++;
      if (rom_rd) nrd++;
      nfo += int'(flag_o); nff += int'(flag_f);
    end
    chk("ack_out_fall", int'(ack_out), 0);
    repeat (4) begin
      cyc();
      if (rom_rd) nrd++;
      nfo += int'(flag_o); nff += int'(flag_f);
    end
    chk("rom_rd_count", nrd, 1);
    chk("flag_o_count", nfo, int'(v.exp_op == 0));
    chk("flag_f_count", nff, int'(v.exp_op == 15));
    chk("opcode_hold", int'(opcode), v.exp_op);
  endtask

  // Reference: opcode/operand are the word's nibbles; JMP loads the PC target, which otherwise holds.
  function automatic vec_t model(input logic [7:0] a, input logic [7:0] w, input int m);
    vec_t v;
    v.addr = a; v.word = w; v.mode = m;
    v.exp_op   = int'(w) / 16;
    v.exp_opnd = int'(w) % 16;
    v.exp_pcw  = int'(v.exp_op == 12);
    if (v.exp_pcw != 0) mdl_pc = v.exp_opnd;
    v.exp_pca  = mdl_pc;
    return v;
  endfunction

  task automatic chk_all_zero(input string nm);
    chk(nm, int'({ack_out, rom_rd, req_out, pc_write, flag_o, flag_f}), 0);
    chk({nm, "_data"}, int'({rom_addr, opcode, operand}) | int'(pc_address), 0);
  endtask

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, nrd;
    vec_t v;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom_data   = 8'h00;
    rst_n      = 1'b0;
    req_in     = 1'b1;
    ack_in     = 1'b0;
    address_in = 8'h00;

    tbl[0] = '{8'h05, 8'h13, 0, 4'h1, 4'h3, 0, 8'h00};
    tbl[1] = '{8'h07, 8'hC9, 0, 4'hC, 4'h9, 1, 8'h09};
    tbl[2] = '{8'h08, 8'h42, 1, 4'h4, 4'h2, 0, 8'h09};
    tbl[3] = '{8'h09, 8'h00, 2, 4'h0, 4'h0, 0, 8'h09};
    tbl[4] = '{8'h0A, 8'hF0, 0, 4'hF, 4'h0, 0, 8'h09};
    tbl[5] = '{8'hFF, 8'hC3, 2, 4'hC, 4'h3, 1, 8'h03};
    tbl[6] = '{8'h00, 8'h7E, 1, 4'h7, 4'hE, 0, 8'h03};

    // Reset with req_in high: outputs idle, and the held request is never serviced.
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;
    nrd = 0;
    repeat (12) begin cyc(); if (rom_rd) nrd++; end
    @(negedge clk);
    req_in = 1'b0;
    repeat (6) begin cyc(); if (rom_rd) nrd++; end
    chk("held_req_ignored", nrd, 0);
    chk_all_zero("post_reset_idle");

    for (int i = 0; i < 7; i++) begin
      do_fetch(tbl[i]);
      if (tbl[i].exp_pcw != 0) mdl_pc = tbl[i].exp_pca;
    end

    for (int i = 0; i < 10; i++) begin
      v = model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
      do_fetch(v);
    end

    // Reset while req_out is high.
    rom[8'h03] = 8'h25;
    @(negedge clk);
    address_in = 8'h03;
    req_in = 1'b1;
    k = 0;
    while (!req_out && k < 30) begin cyc(); k++; end
    chk("mid_reset_reached_issue", int'(req_out), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_req_out", int'(req_out), 0);
    chk("mid_reset_ack_out", int'(ack_out), 0);
    req_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) cyc();
    mdl_pc = 0;
    v = model(8'h03, 8'h25, 0);
    do_fetch(v);

    // Reset while ack_out is high.
    @(negedge clk);
    address_in = 8'h11;
    rom[8'h11] = 8'hC6;
    req_in = 1'b1;
    k = 0;
    while (!req_out && k < 30) begin cyc(); k++; end
    ack_in = 1'b1;
    k = 0;
    while (!ack_out && k < 30) begin cyc(); k++; end
    chk("release_reached", int'(ack_out), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("release_reset_ack_out", int'(ack_out), 0);
    chk("release_reset_pc_write", int'(pc_write), 0);
    req_in = 1'b0;
    ack_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) cyc();
    mdl_pc = 0;
    v = model(8'h12, 8'hC4, 1);
    do_fetch(v);
    v = model(8'h13, 8'h8B, 2);
    do_fetch(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
